memory_unit: RTL and testbench

Memory responder for the 8-bit microcoded CPU: the other end of the control unit's `memory_op` interface. It decodes `memory_op` commands, holds the data address register and the program counter, and performs byte reads and writes on an internal RAM with configurable wait states. A `ready` handshake lets the sequencer stall on multi-cycle accesses. Read and fetch data go onto the shared 8-bit bus.

---
 rtl/memory_unit.sv | 180 ++++++++++++++++++
 tb/tb_memory_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_unit.sv
// memory_unit: memory responder for the 8-bit microcoded CPU.
// Decodes memory_op commands, holds the data address (addr) and program
// counter (pc), and performs byte reads/writes on an internal RAM with
// WAIT_STATES extra busy cycles per READ, WRITE or FETCH.
//
// Ports:
//   clock              system clock, rising edge
//   reset_n            synchronous active-low reset
//   memory_op          command from the control unit (memory_op_e)
//   data_word_selector byte select for MEM_ADDR_SET (0 = low, 1 = high)
//   bus_in             bus value, sampled when a command is accepted
//   bus_out            read/fetch data, valid for the DONE cycle only
//   bus_drive          bus_out valid, bus mux must select memory
//   ready              idle, a new command can be accepted
//   fault              one-cycle pulse on a blocked write
//
// Optional feature macro: MEMORY_UNIT_ROM_PROTECT_EN
//   defined   -> writes below ROM_TOP are dropped and pulse fault
//   undefined -> every address is writable, fault stays 0

package memory_unit_pkg;
    typedef enum logic [2:0] {
        MEM_NOP      = 3'd0,
        MEM_ADDR_SET = 3'd1,
        MEM_READ     = 3'd2,
        MEM_WRITE    = 3'd3,
        MEM_FETCH    = 3'd4,
        MEM_JUMP     = 3'd5
    } memory_op_e;
endpackage

module memory_unit
    import memory_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ROM_TOP     = 'h100
) (
    input  logic             clock,
    input  logic             reset_n,
    input  memory_op_e       memory_op,
    input  logic             data_word_selector,
    input  logic [7:0]       bus_in,
    output logic [7:0]       bus_out,
    output logic             bus_drive,
    output logic             ready,
    output logic             fault
);

    localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W   = 4;
`ifdef MEMORY_UNIT_ROM_PROTECT_EN
    localparam bit          PROTECT = 1'b1;
`else
    localparam bit          PROTECT = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [15:0]             addr_q, addr_d;
    logic [15:0]             pc_q, pc_d;
    memory_op_e              op_q, op_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [7:0]              data_q, data_d;
    logic [7:0]              bus_out_d;
    logic                    bus_drive_d;
    logic                    fault_d;
    logic                    ready_d;
    logic                    mem_we_c;
    logic                    blocked_d_c;
    logic                    blocked_q_c;

    logic [7:0]              mem_q [DEPTH];

    // Write protection: only meaningful when the protect feature is built in.
    assign blocked_d_c = PROTECT && (32'(idx_d) < ROM_TOP);
    assign blocked_q_c = PROTECT && (32'(idx_q) < ROM_TOP);

    // Next-state, register updates and DONE-cycle outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        pc_d        = pc_q;
        op_d        = op_q;
        idx_d       = idx_q;
        data_d      = data_q;
        bus_out_d   = 8'h00;
        bus_drive_d = 1'b0;
        fault_d     = 1'b0;
        mem_we_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                case (memory_op)
                    MEM_ADDR_SET: begin
                        if (data_word_selector) addr_d[15:8] = bus_in;
                        else                    addr_d[7:0]  = bus_in;
                    end
                    MEM_JUMP: pc_d = addr_q;
                    MEM_READ, MEM_WRITE, MEM_FETCH: begin
                        op_d   = memory_op;
                        idx_d  = (memory_op == MEM_FETCH) ? pc_q[ADDR_WIDTH-1:0]
                                                          : addr_q[ADDR_WIDTH-1:0];
                        data_d = bus_in;
                        if (WAIT_STATES == 0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = CNT_W'(WAIT_STATES);
                        end
                    end
                    default: ;
                endcase
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (op_q == MEM_WRITE && !blocked_q_c) mem_we_c = 1'b1;
                if (op_q == MEM_FETCH) pc_d = pc_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered on entry to DONE so they are valid exactly there.
        if (state_d == ST_DONE) begin
            if (op_d == MEM_READ || op_d == MEM_FETCH) begin
                bus_out_d   = mem_q[idx_d];
                bus_drive_d = 1'b1;
            end
            if (op_d == MEM_WRITE && blocked_d_c) fault_d = 1'b1;
        end

        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            pc_q      <= '0;
            op_q      <= MEM_NOP;
            idx_q     <= '0;
            data_q    <= '0;
            bus_out   <= '0;
            bus_drive <= 1'b0;
            fault     <= 1'b0;
            ready     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            pc_q      <= pc_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            bus_out   <= bus_out_d;
            bus_drive <= bus_drive_d;
            fault     <= fault_d;
            ready     <= ready_d;
        end
    end

    // RAM is not reset; a write that reached DONE commits even if reset is asserted.
    always_ff @(posedge clock) begin
        if (mem_we_c) mem_q[idx_q] <= data_q;
    end

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit: directed scenarios plus random
// command traffic, compared against a transaction-level model of the RAM,
// addr and pc. A second instance with WAIT_STATES=3 covers reset mid-write.
module tb_memory_unit;
    import memory_unit_pkg::*;

    localparam int unsigned AW  = 12;
    localparam int unsigned ROM = 'h100;
`ifdef MEMORY_UNIT_ROM_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    memory_op_e memory_op;
    logic       sel;
    logic [7:0] bus_in;
    bit         use3;

    memory_op_e op1, op3;
    logic [7:0] bus_out1, bus_out3;
    logic       bus_drive1, bus_drive3, ready1, ready3, fault1, fault3;

    assign op1 = use3 ? MEM_NOP : memory_op;
    assign op3 = use3 ? memory_op : MEM_NOP;

    memory_unit #(.ADDR_WIDTH(AW), .WAIT_STATES(1), .ROM_TOP(ROM)) dut (
        .clock(clock), .reset_n(reset_n), .memory_op(op1),
        .data_word_selector(sel), .bus_in(bus_in), .bus_out(bus_out1),
        .bus_drive(bus_drive1), .ready(ready1), .fault(fault1));

    memory_unit #(.ADDR_WIDTH(AW), .WAIT_STATES(3), .ROM_TOP(ROM)) dut3 (
        .clock(clock), .reset_n(reset_n), .memory_op(op3),
        .data_word_selector(sel), .bus_in(bus_in), .bus_out(bus_out3),
        .bus_drive(bus_drive3), .ready(ready3), .fault(fault3));

    wire [7:0]  bout   = use3 ? bus_out3   : bus_out1;
    wire        bdrv   = use3 ? bus_drive3 : bus_drive1;
    wire        rdy    = use3 ? ready3     : ready1;
    wire        flt_o  = use3 ? fault3     : fault1;
    wire [15:0] obs_pc   = use3 ? dut3.pc_q   : dut.pc_q;
    wire [15:0] obs_addr = use3 ? dut3.addr_q : dut.addr_q;

    always #5 clock = ~clock;

    // Reference model
    logic [7:0]  mem_m [1 << AW];
    bit          val_m [1 << AW];
    logic [15:0] addr_m, pc_m;
    int          compared = 0;
    int          failed   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ws();
        return use3 ? 3 : 1;
    endfunction

    task automatic model_reset();
        addr_m = 16'h0;
        pc_m   = 16'h0;
    endtask

    // Issue one command, watch the busy window, compare against the model.
    task automatic exec(input memory_op_e op, input logic s, input logic [7:0] d,
                        output logic [7:0] got);
        int busy, drv, flts;
        bit bad, known, blocked, multi, rd;
        logic [AW-1:0] idx;
        logic [7:0] exp;
        idx     = (op == MEM_FETCH) ? pc_m[AW-1:0] : addr_m[AW-1:0];
        exp     = mem_m[idx];
        known   = val_m[idx];
        blocked = PROT && (32'(idx) < ROM);
        multi   = (op == MEM_READ) || (op == MEM_WRITE) || (op == MEM_FETCH);
        rd      = (op == MEM_READ) || (op == MEM_FETCH);

        memory_op = op; sel = s; bus_in = d;
        @(posedge clock); #1;
        memory_op = MEM_NOP;
        busy = 0; drv = 0; flts = 0; bad = 0; got = 8'h00;
        while (!rdy && busy < 40) begin
            busy++;
            if (bdrv) begin drv++; got = bout; end
            else if (bout !== 8'h00) bad = 1;
            if (flt_o) flts++;
            @(posedge clock); #1;
        end

        case (op)
            MEM_ADDR_SET: if (s) addr_m[15:8] = d; else addr_m[7:0] = d;
            MEM_JUMP:     pc_m = addr_m;
            MEM_WRITE:    if (!blocked) begin mem_m[idx] = d; val_m[idx] = 1'b1; end
            MEM_FETCH:    pc_m = pc_m + 16'd1;
            default: ;
        endcase

        check("busy_cycles", 32'(busy), multi ? 32'(ws() + 1) : 32'd0);
        check("drive_cycles", 32'(drv), rd ? 32'd1 : 32'd0);
        if (rd && known) check("rd_data", 32'(got), 32'(exp));
        check("fault_cycles", 32'(flts), (op == MEM_WRITE && blocked) ? 32'd1 : 32'd0);
        check("bus_out_idle_zero", 32'(bad), 32'd0);
        check("addr", 32'(obs_addr), 32'(addr_m));
        check("pc", 32'(obs_pc), 32'(pc_m));
    endtask

    task automatic set_addr(input logic [15:0] a);
        logic [7:0] g;
        exec(MEM_ADDR_SET, 1'b0, a[7:0], g);
        exec(MEM_ADDR_SET, 1'b1, a[15:8], g);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(rdy), 32'd1);
        check({tag, "_bus_drive"}, 32'(bdrv), 32'd0);
        check({tag, "_bus_out"}, 32'(bout), 32'd0);
        check({tag, "_fault"}, 32'(flt_o), 32'd0);
        check({tag, "_pc"}, 32'(obs_pc), 32'd0);
        check({tag, "_addr"}, 32'(obs_addr), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] g, g0, b1, b2;
        int busy;
        for (int i = 0; i < (1 << AW); i++) val_m[i] = 1'b0;
        use3 = 1'b0; memory_op = MEM_NOP; sel = 1'b0; bus_in = 8'h00;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("por");
        reset_n = 1'b1;

        // Reset asserted for two cycles in the middle of a FETCH
        set_addr(16'h0123);
        exec(MEM_JUMP, 1'b0, 8'h00, g);
        memory_op = MEM_FETCH;
        @(posedge clock); #1;
        memory_op = MEM_NOP;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        check_reset_outputs("rst_mid_fetch");
        reset_n = 1'b1;

        // Address set, write, read back
        exec(MEM_ADDR_SET, 1'b0, 8'h34, g);
        exec(MEM_ADDR_SET, 1'b1, 8'h02, g);
        exec(MEM_WRITE, 1'b0, 8'hA5, g);
        exec(MEM_READ, 1'b0, 8'h00, g);
        check("read_0x234", 32'(g), 32'hA5);

        // WRITE presented while busy with a READ must be ignored
        memory_op = MEM_READ;
        @(posedge clock); #1;
        memory_op = MEM_WRITE; bus_in = 8'h11;
        busy = 0; g = 8'h00;
        while (!rdy && busy < 40) begin
            busy++;
            if (bdrv) g = bout;
            @(posedge clock); #1;
        end
        memory_op = MEM_NOP;
        check("busy_ignore_cycles", 32'(busy), 32'd2);
        check("busy_ignore_read", 32'(g), 32'hA5);
        exec(MEM_READ, 1'b0, 8'h00, g);

        // Fetch across the top of the RAM index space
        b1 = 8'($urandom); b2 = 8'($urandom);
        set_addr(16'h0FFF);
        exec(MEM_WRITE, 1'b0, b1, g);
        set_addr(16'h0000);
        exec(MEM_WRITE, 1'b0, b2, g);
        set_addr(16'h0FFF);
        exec(MEM_JUMP, 1'b0, 8'h00, g);
        exec(MEM_FETCH, 1'b0, 8'h00, g);
        check("fetch_top", 32'(g), 32'(b1));
        exec(MEM_FETCH, 1'b0, 8'h00, g);
        check("pc_wrap", 32'(obs_pc), 32'h1001);

        // Random command traffic
        for (int n = 0; n < 120; n++) begin
            int r;
            logic s;
            logic [7:0] d;
            r = int'($urandom_range(0, 9));
            s = 1'($urandom);
            d = 8'($urandom);
            case (r)
                0, 1, 2: begin
                    if (s) d = 8'($urandom_range(0, 15));
                    exec(MEM_ADDR_SET, s, d, g);
                end
                3, 4: exec(MEM_WRITE, 1'b0, d, g);
                5, 6: exec(MEM_READ, 1'b0, 8'h00, g);
                7:    exec(MEM_FETCH, 1'b0, 8'h00, g);
                8:    exec(MEM_JUMP, 1'b0, 8'h00, g);
                default: exec(MEM_NOP, 1'b0, d, g);
            endcase
        end

        // Protection boundary: 0x0010 (below ROM_TOP) and 0x0100 (first writable)
        set_addr(16'h0010);
        exec(MEM_READ, 1'b0, 8'h00, g0);
        if (!val_m[16]) begin mem_m[16] = g0; val_m[16] = 1'b1; end
        exec(MEM_WRITE, 1'b0, 8'h55, g);
        exec(MEM_READ, 1'b0, 8'h00, g);
        check("low_write_result", 32'(g), PROT ? 32'(g0) : 32'h55);
        set_addr(16'h0100);
        exec(MEM_WRITE, 1'b0, 8'h66, g);
        exec(MEM_READ, 1'b0, 8'h00, g);
        check("rom_top_write", 32'(g), 32'h66);

        // WAIT_STATES=3 instance: reset during the WAIT state of a WRITE
        use3 = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < (1 << AW); i++) val_m[i] = 1'b0;
        check_reset_outputs("ws3_reset");
        set_addr(16'h0300);
        exec(MEM_WRITE, 1'b0, 8'h3C, g);
        exec(MEM_READ, 1'b0, 8'h00, g);
        check("ws3_read_before", 32'(g), 32'h3C);
        memory_op = MEM_WRITE; bus_in = 8'h77;
        @(posedge clock); #1;
        memory_op = MEM_NOP;
        @(posedge clock); #1;
        check("ws3_in_wait", 32'(rdy), 32'd0);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
        check_reset_outputs("rst_mid_write");
        set_addr(16'h0300);
        exec(MEM_READ, 1'b0, 8'h00, g);
        check("rst_mid_write_ram", 32'(g), 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
